icache_fetch_ctrl: RTL and testbench

Parametrised code-fetch controller between the prefetch unit and the L1 instruction cache. It accepts a byte-granular fetch request, issues word-aligned burst reads to the cache, and trims each returned word to the requested byte window. It emits tagged entries into the prefetch FIFO and reports consumed byte counts. Unlike the previous generation, burst length is configurable, and an optional chain mode continues automatically into the next burst until the requested length is exhausted.

---
 rtl/icache_fetch_ctrl_if.sv | 34 +++
 rtl/icache_fetch_ctrl.sv | 135 +++++++++++++
 tb/tb_icache_fetch_ctrl.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/icache_fetch_ctrl_if.sv
// Fetch controller bus bundle: prefetch request side, cache burst side and
// prefetch FIFO write side. The controller is the master.
interface icache_fetch_ctrl_if #(
  parameter int LEN_W = 5
);
  logic             pr_reset;
  logic             fetch_do;
  logic [31:0]      fetch_address;
  logic [LEN_W-1:0] fetch_length;
  logic             fetch_busy;
  logic             cache_req;
  logic [31:0]      cache_address;
  logic             cache_valid;
  logic             cache_done;
  logic [31:0]      cache_data;
  logic             fifo_write_do;
  logic [35:0]      fifo_write_data;
  logic             prefetched_do;
  logic [4:0]       prefetched_length;

  modport master (
    input  pr_reset, fetch_do, fetch_address, fetch_length,
    input  cache_valid, cache_done, cache_data,
    output fetch_busy, cache_req, cache_address,
    output fifo_write_do, fifo_write_data, prefetched_do, prefetched_length
  );

  modport slave (
    output pr_reset, fetch_do, fetch_address, fetch_length,
    output cache_valid, cache_done, cache_data,
    input  fetch_busy, cache_req, cache_address,
    input  fifo_write_do, fifo_write_data, prefetched_do, prefetched_length
  );
endinterface

// File: rtl/icache_fetch_ctrl.sv
// Code-fetch controller: turns a byte-granular fetch into word-aligned cache
// bursts, trims each returned word to the requested window and tags it with
// its byte count. Optional chaining continues into following bursts.
module icache_fetch_ctrl #(
  parameter int BURST_WORDS = 4,
  parameter int LEN_W       = 5,
  parameter int CHAIN       = 1
) (
  input  logic               clk,
  input  logic               reset,
  icache_fetch_ctrl_if.master bus
);
  localparam int BEAT_W = $clog2(BURST_WORDS) + 1;

  typedef enum logic [1:0] {IDLE, WAIT, NEXT, DRAIN} state_t;

  state_t           state, state_nxt;
  logic [LEN_W-1:0] remaining, remaining_nxt;
  logic [1:0]       offset, offset_nxt;
  logic [29:0]      waddr, waddr_nxt;
  logic [BEAT_W-1:0] beat, beat_nxt;
  logic             first, first_nxt;

  logic             accept;
  logic             beat_ok;
  logic             wr;
  logic             req;
  logic [31:0]      req_addr;
  logic [2:0]       avail;
  logic [2:0]       n;
  logic [31:0]      shifted;

  assign accept  = (state == IDLE) && bus.fetch_do && (bus.fetch_length != '0) && !bus.pr_reset;
  // Beats past the burst length are a protocol error: counter saturates, word dropped.
  assign beat_ok = beat < BEAT_W'(BURST_WORDS);

  // Byte window of the current beat: only the first beat of the first burst
  // starts mid-word; the count is further clipped by what is left.
  always_comb begin
    avail   = (beat == '0 && first) ? 3'd4 - {1'b0, offset} : 3'd4;
    n       = (remaining < LEN_W'(avail)) ? remaining[2:0] : avail;
    shifted = bus.cache_data >> {3'd4 - avail, 3'b000};
  end

  assign wr = (state == WAIT) && bus.cache_valid && !bus.pr_reset && beat_ok && (remaining != '0);

  // State register and fetch context.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      remaining <= '0;
      offset    <= '0;
      waddr     <= '0;
      beat      <= '0;
      first     <= 1'b0;
    end else begin
      state     <= state_nxt;
      remaining <= remaining_nxt;
      offset    <= offset_nxt;
      waddr     <= waddr_nxt;
      beat      <= beat_nxt;
      first     <= first_nxt;
    end
  end

  // Next state, context updates and the burst request.
  always_comb begin
    state_nxt     = state;
    remaining_nxt = remaining;
    offset_nxt    = offset;
    waddr_nxt     = waddr;
    beat_nxt      = beat;
    first_nxt     = first;
    req           = 1'b0;
    req_addr      = {waddr, 2'b00};
    case (state)
      IDLE: begin
        if (accept) begin
          req           = 1'b1;
          req_addr      = {bus.fetch_address[31:2], 2'b00};
          remaining_nxt = bus.fetch_length;
          offset_nxt    = bus.fetch_address[1:0];
          waddr_nxt     = bus.fetch_address[31:2];
          beat_nxt      = '0;
          first_nxt     = 1'b1;
          state_nxt     = WAIT;
        end
      end
      WAIT: begin
        if (bus.pr_reset) begin
          // Burst still in flight unless it ends this very cycle.
          state_nxt = bus.cache_done ? IDLE : DRAIN;
        end else begin
          if (bus.cache_valid && beat_ok) begin
            beat_nxt = beat + 1'b1;
            if (remaining != '0) remaining_nxt = remaining - LEN_W'(n);
          end
          if (bus.cache_done) begin
            if (CHAIN != 0 && remaining_nxt != '0) begin
              waddr_nxt = waddr + 30'(BURST_WORDS);
              state_nxt = NEXT;
            end else begin
              state_nxt = IDLE;
            end
          end
        end
      end
      NEXT: begin
        if (bus.pr_reset) begin
          state_nxt = IDLE;
        end else begin
          req       = 1'b1;
          beat_nxt  = '0;
          first_nxt = 1'b0;
          state_nxt = WAIT;
        end
      end
      DRAIN: begin
        if (bus.cache_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are held at zero while reset is asserted, even the combinational ones.
  always_comb begin
    bus.fetch_busy        = !reset && (state != IDLE);
    bus.cache_req         = !reset && req;
    bus.cache_address     = reset ? 32'd0 : req_addr;
    bus.fifo_write_do     = !reset && wr;
    bus.fifo_write_data   = (!reset && wr) ? {1'b0, n, shifted} : 36'd0;
    bus.prefetched_do     = !reset && wr;
    bus.prefetched_length = (!reset && wr) ? {2'b00, n} : 5'd0;
  end
endmodule

// File: tb/tb_icache_fetch_ctrl.sv
// Directed bench: u0 is a single-burst instance (BURST_WORDS=4, CHAIN=0),
// u1 a chaining instance (BURST_WORDS=2, CHAIN=1).
module tb_icache_fetch_ctrl;
  logic clk;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  icache_fetch_ctrl_if #(.LEN_W(5)) b0 ();
  icache_fetch_ctrl_if #(.LEN_W(5)) b1 ();

  icache_fetch_ctrl #(.BURST_WORDS(4), .LEN_W(5), .CHAIN(0)) u0 (.clk(clk), .reset(reset), .bus(b0));
  icache_fetch_ctrl #(.BURST_WORDS(2), .LEN_W(5), .CHAIN(1)) u1 (.clk(clk), .reset(reset), .bus(b1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    b0.pr_reset = 0; b0.fetch_do = 0; b0.fetch_address = 0; b0.fetch_length = 0;
    b0.cache_valid = 0; b0.cache_done = 0; b0.cache_data = 0;
    b1.pr_reset = 0; b1.fetch_do = 0; b1.fetch_address = 0; b1.fetch_length = 0;
    b1.cache_valid = 0; b1.cache_done = 0; b1.cache_data = 0;
  endtask

  initial begin
    reset = 1'b1;
    clr();
    @(negedge clk);
    // Reset: outputs zero even with a live request presented.
    b0.fetch_do = 1; b0.fetch_address = 32'h1000; b0.fetch_length = 16;
    b1.fetch_do = 1; b1.fetch_address = 32'h1000; b1.fetch_length = 16;
    #1;
    chk("rst_req0", b0.cache_req, 0);
    chk("rst_busy0", b0.fetch_busy, 0);
    chk("rst_wr0", b0.fifo_write_do, 0);
    chk("rst_addr0", b0.cache_address, 0);
    chk("rst_req1", b1.cache_req, 0);
    chk("rst_busy1", b1.fetch_busy, 0);
    @(negedge clk);
    clr();
    reset = 1'b0;
    @(negedge clk);

    // Aligned single burst, 16 bytes.
    b0.fetch_do = 1; b0.fetch_address = 32'h1000; b0.fetch_length = 16;
    #1;
    chk("al_req", b0.cache_req, 1);
    chk("al_addr", b0.cache_address, 32'h1000);
    @(negedge clk);
    b0.fetch_do = 0;
    #1;
    chk("al_busy", b0.fetch_busy, 1);
    chk("al_noreq", b0.cache_req, 0);
    for (int i = 0; i < 4; i++) begin
      b0.cache_valid = 1; b0.cache_data = 32'h11111111 * (i + 1); b0.cache_done = (i == 3);
      #1;
      chk("al_wr", b0.fifo_write_do, 1);
      chk("al_data", b0.fifo_write_data, {4'd4, 32'h11111111 * (i + 1)});
      chk("al_plen", b0.prefetched_length, 4);
      @(negedge clk);
    end
    clr();
    #1;
    chk("al_idle", b0.fetch_busy, 0);
    @(negedge clk);

    // Unaligned start: 0x1003, 5 bytes.
    b0.fetch_do = 1; b0.fetch_address = 32'h1003; b0.fetch_length = 5;
    #1;
    chk("un_addr", b0.cache_address, 32'h1000);
    @(negedge clk);
    b0.fetch_do = 0;
    b0.cache_valid = 1; b0.cache_data = 32'hAABBCCDD;
    #1;
    chk("un_w0", b0.fifo_write_data, {4'd1, 32'h000000AA});
    @(negedge clk);
    b0.cache_data = 32'h44332211;
    #1;
    chk("un_w1", b0.fifo_write_data, {4'd4, 32'h44332211});
    @(negedge clk);
    b0.cache_data = 32'h99999999;
    #1;
    chk("un_drop2", b0.fifo_write_do, 0);
    @(negedge clk);
    b0.cache_done = 1;
    #1;
    chk("un_drop3", b0.fifo_write_do, 0);
    @(negedge clk);
    clr();
    #1;
    chk("un_idle", b0.fetch_busy, 0);
    @(negedge clk);

    // Abort in beat 2 of 4, then a fetch held through DRAIN.
    b0.fetch_do = 1; b0.fetch_address = 32'h3000; b0.fetch_length = 16;
    @(negedge clk);
    b0.fetch_do = 0;
    b0.cache_valid = 1; b0.cache_data = 32'h01020304;
    @(negedge clk);
    @(negedge clk);
    b0.pr_reset = 1;
    #1;
    chk("ab_nowr", b0.fifo_write_do, 0);
    @(negedge clk);
    b0.pr_reset = 0;
    b0.fetch_do = 1; b0.fetch_address = 32'h4000; b0.fetch_length = 4;
    #1;
    chk("ab_drain_busy", b0.fetch_busy, 1);
    chk("ab_drain_nowr", b0.fifo_write_do, 0);
    chk("ab_drain_noreq", b0.cache_req, 0);
    @(negedge clk);
    b0.cache_done = 1;
    #1;
    chk("ab_done_nowr", b0.fifo_write_do, 0);
    chk("ab_done_noreq", b0.cache_req, 0);
    @(negedge clk);
    b0.cache_done = 0; b0.cache_valid = 0;
    #1;
    chk("ab_idle_busy", b0.fetch_busy, 0);
    chk("ab_new_req", b0.cache_req, 1);
    chk("ab_new_addr", b0.cache_address, 32'h4000);
    @(negedge clk);
    b0.fetch_do = 0;
    b0.cache_valid = 1; b0.cache_done = 1; b0.cache_data = 32'h55667788;
    #1;
    chk("ab_new_wr", b0.fifo_write_data, {4'd4, 32'h55667788});
    @(negedge clk);
    clr();
    #1;
    chk("ab_new_idle", b0.fetch_busy, 0);
    @(negedge clk);

    // Chain: 0x2002, 12 bytes, 2-word bursts.
    b1.fetch_do = 1; b1.fetch_address = 32'h2002; b1.fetch_length = 12;
    #1;
    chk("ch_req0", b1.cache_req, 1);
    chk("ch_addr0", b1.cache_address, 32'h2000);
    @(negedge clk);
    b1.fetch_do = 0;
    b1.cache_valid = 1; b1.cache_data = 32'hDDCCBBAA;
    #1;
    chk("ch_w0", b1.fifo_write_data, {4'd2, 32'h0000DDCC});
    @(negedge clk);
    b1.cache_data = 32'h44332211; b1.cache_done = 1;
    #1;
    chk("ch_w1", b1.fifo_write_data, {4'd4, 32'h44332211});
    chk("ch_done_noreq", b1.cache_req, 0);
    @(negedge clk);
    b1.cache_valid = 0; b1.cache_done = 0;
    #1;
    chk("ch_req1", b1.cache_req, 1);
    chk("ch_addr1", b1.cache_address, 32'h2008);
    chk("ch_busy", b1.fetch_busy, 1);
    @(negedge clk);
    b1.cache_valid = 1; b1.cache_data = 32'h88776655;
    #1;
    chk("ch_w2", b1.fifo_write_data, {4'd4, 32'h88776655});
    @(negedge clk);
    b1.cache_data = 32'hCAFEF00D; b1.cache_done = 1;
    #1;
    chk("ch_w3_len", b1.prefetched_length, 2);
    chk("ch_w3", b1.fifo_write_data, {4'd2, 32'hCAFEF00D});
    @(negedge clk);
    clr();
    #1;
    chk("ch_idle", b1.fetch_busy, 0);
    chk("ch_idle_noreq", b1.cache_req, 0);
    @(negedge clk);

    // pr_reset together with cache_done in WAIT: no write, no chained request.
    b1.fetch_do = 1; b1.fetch_address = 32'h5000; b1.fetch_length = 16;
    @(negedge clk);
    b1.fetch_do = 0;
    b1.cache_valid = 1; b1.cache_data = 32'h0A0B0C0D;
    #1;
    chk("sd_w0", b1.fifo_write_data, {4'd4, 32'h0A0B0C0D});
    @(negedge clk);
    b1.cache_done = 1; b1.pr_reset = 1;
    #1;
    chk("sd_nowr", b1.fifo_write_do, 0);
    @(negedge clk);
    clr();
    #1;
    chk("sd_idle", b1.fetch_busy, 0);
    chk("sd_nochain", b1.cache_req, 0);
    @(negedge clk);

    // Asynchronous reset in the middle of a beat.
    b0.fetch_do = 1; b0.fetch_address = 32'h6000; b0.fetch_length = 8;
    @(negedge clk);
    b0.fetch_do = 0;
    b0.cache_valid = 1; b0.cache_data = 32'h13579BDF;
    #1;
    chk("ar_wr", b0.fifo_write_do, 1);
    reset = 1'b1;
    #1;
    chk("ar_wr0", b0.fifo_write_do, 0);
    chk("ar_len0", b0.prefetched_length, 0);
    chk("ar_busy0", b0.fetch_busy, 0);
    reset = 1'b0;
    b0.cache_valid = 0;
    @(negedge clk);
    #1;
    chk("ar_idle", b0.fetch_busy, 0);
    b0.fetch_do = 1; b0.fetch_address = 32'h7001; b0.fetch_length = 3;
    #1;
    chk("ar_req", b0.cache_req, 1);
    chk("ar_addr", b0.cache_address, 32'h7000);
    @(negedge clk);
    b0.fetch_do = 0;
    b0.cache_valid = 1; b0.cache_done = 1; b0.cache_data = 32'h12345678;
    #1;
    chk("ar_w", b0.fifo_write_data, {4'd3, 32'h00123456});
    @(negedge clk);
    clr();
    #1;
    chk("ar_end_idle", b0.fetch_busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
